// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional feature macro used by this slice: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on instr while nothing is fetched
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } fetch_state_e;

  // Source selection for the next fetch address
  typedef enum logic [1:0] {
    NXT_KEEP,
    NXT_INC,
    NXT_TARGET,
    NXT_PENDING
  } nxt_sel_e;

  // Word-align an address by clearing its two low bits
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Fetch-address register, pending-redirect register and next-address mux.
// With FETCH_MISALIGN_TRAP_EN defined, a redirect target whose low two bits
// are non-zero is replaced by TRAP_VEC and reported on 'misaligned'.
module pc_next
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  nxt_sel_e        nxt_sel,
  input  logic            pend_load,
  input  logic [XLEN-1:0] alu_data,
  output logic [XLEN-1:0] fetch_addr
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic          misaligned
`endif
);

  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] redirect_addr;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned    = |alu_data[1:0];
  assign redirect_addr = misaligned ? TRAP_VEC : alu_data;
`else
  assign redirect_addr = align_word(alu_data);
`endif

  assign fetch_addr = fetch_addr_q;

  // Choose the next fetch address and capture a redirect that must wait for the bus
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    pending_d    = pending_q;
    if (pend_load) begin
      pending_d = redirect_addr;
    end
    case (nxt_sel)
      NXT_INC:     fetch_addr_d = fetch_addr_q + 32'd4;
      NXT_TARGET:  fetch_addr_d = redirect_addr;
      NXT_PENDING: fetch_addr_d = pending_q;
      default:     fetch_addr_d = fetch_addr_q;
    endcase
  end

  // Address registers, cleared asynchronously so a reset abandons any redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= RESET_PC;
      pending_q    <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pending_q    <= pending_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem requests, hands fetched words to
// decode, honours stalls and branch/jump redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the 'trap' output and
// redirects misaligned targets to TRAP_VEC).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_sel,
  input  logic [31:0] alu_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_vld,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        flush
`ifdef FETCH_MISALIGN_TRAP_EN
  , output logic      trap
`endif
);

  fetch_state_e    state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_vld_q, instr_vld_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  nxt_sel_e        nxt_sel;
  logic            pend_load;
  logic [XLEN-1:0] fetch_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            trap_q, trap_d;
`endif

  pc_next #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) u_pc_next (
    .clk        (clk),
    .rst_n      (rst_n),
    .nxt_sel    (nxt_sel),
    .pend_load  (pend_load),
    .alu_data   (alu_data),
    .fetch_addr (fetch_addr)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misaligned (misaligned)
`endif
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = fetch_addr;
  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign pc        = pc_q;
  assign pc_four   = pc_q + 32'd4;
  assign flush     = flush_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap      = trap_q;
`endif

  // Next state, next registered outputs and address-mux control; br_sel wins over stall
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    nxt_sel     = NXT_KEEP;
    pend_load   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d     = REQ;
        imem_req_d  = 1'b1;
        instr_vld_d = 1'b0;
      end
      REQ: begin
        imem_req_d  = 1'b1;
        instr_vld_d = 1'b0;
        if (br_sel) begin
          flush_d = 1'b1;
          if (imem_ack) begin
            nxt_sel = NXT_TARGET;
          end else begin
            pend_load = 1'b1;
            state_d   = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d     = imem_rdata;
          instr_vld_d = 1'b1;
          pc_d        = fetch_addr;
          nxt_sel     = NXT_INC;
          if (stall) begin
            state_d    = HOLD;
            imem_req_d = 1'b0;
          end
        end
      end
      HOLD: begin
        imem_req_d = 1'b0;
        if (br_sel) begin
          instr_vld_d = 1'b0;
          nxt_sel     = NXT_TARGET;
          flush_d     = 1'b1;
          state_d     = REQ;
          imem_req_d  = 1'b1;
        end else if (!stall) begin
          instr_vld_d = 1'b0;
          state_d     = REQ;
          imem_req_d  = 1'b1;
        end
      end
      DRAIN: begin
        imem_req_d  = 1'b1;
        instr_vld_d = 1'b0;
        if (br_sel) begin
          flush_d = 1'b1;
          if (imem_ack) begin
            nxt_sel = NXT_TARGET;
            state_d = REQ;
          end else begin
            pend_load = 1'b1;
          end
        end else if (imem_ack) begin
          nxt_sel = NXT_PENDING;
          state_d = REQ;
        end
      end
      default: begin
        state_d     = IDLE;
        imem_req_d  = 1'b0;
        instr_vld_d = 1'b0;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d = flush_d & misaligned;
`endif
  end

  // FSM state and registered outputs, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      instr_q     <= INSTR_NOP;
      instr_vld_q <= 1'b0;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the redirect address for a misaligned branch target.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port br_sel, input, 1, the branch/jump redirect request.
REQ-006 SHALL have port alu_data, input, 32, the redirect target, valid when br_sel=1.
REQ-007 SHALL have port stall, input, 1, the hazard hold from the decode/execute stages.
REQ-008 SHALL have port imem_req, output, 1, the instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32, the instruction memory address.
REQ-010 SHALL have port imem_ack, input, 1, the memory completion; imem_rdata is valid in the same cycle.
REQ-011 SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-012 SHALL have port instr, output, 32, the instruction to decode.
REQ-013 SHALL have port instr_vld, output, 1, meaning instr is valid.
REQ-014 SHALL have port pc, output, 32, the address of instr.
REQ-015 SHALL have port pc_four, output, 32, equal to pc+4.
REQ-016 SHALL have port flush, output, 1, a one-cycle pulse on any accepted redirect.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, HOLD and DRAIN.
REQ-018 SHALL leave IDLE for REQ exactly one cycle after rst_n deasserts.
REQ-019 In REQ, SHALL drive imem_req=1 and imem_addr=fetch address.
REQ-020 SHALL keep imem_addr stable while imem_req=1 and imem_ack=0.
REQ-021 On REQ with imem_ack=1 and no redirect, SHALL register instr=imem_rdata, set instr_vld=1 and pc=fetch address.
REQ-022 After such an ack, SHALL advance the fetch address by 4 with wrap modulo 2^32, so 32'hFFFF_FFFC becomes 32'h0.
REQ-023 After such an ack, SHALL go to HOLD if stall=1, else stay in REQ, giving back-to-back fetch with no bubble.
REQ-024 In HOLD, SHALL keep instr, instr_vld and pc stable with imem_req=0, and return to REQ in the first cycle with stall=0.
REQ-025 When stall=0, SHALL keep instr_vld high for exactly one cycle per accepted word; instr_vld SHALL be 0 in cycles with no new ack.
REQ-026 On br_sel=1 in REQ with imem_ack=0, SHALL store the target in a pending register, pulse flush, clear instr_vld, and go to DRAIN.
REQ-027 In DRAIN, SHALL keep the request and discard the data on ack, leaving instr_vld=0.
REQ-028 On that ack, SHALL set the fetch address to the pending target and return to REQ.
REQ-029 On br_sel=1 in the same cycle as imem_ack=1, SHALL discard the data, load the fetch address from alu_data, pulse flush, and stay in REQ.
REQ-030 On br_sel=1 in HOLD, SHALL drop the held instruction, clear instr_vld, load the target, pulse flush, and go to REQ.
REQ-031 On br_sel=1 while in DRAIN, SHALL let the newest target overwrite the pending register and pulse flush again.
REQ-032 SHALL give br_sel precedence over stall.
REQ-033 SHALL keep pc_four combinational as pc+4, wrapping on overflow.

Reset
REQ-034 While rst_n=0, SHALL immediately (asynchronously) set: state=IDLE, fetch address=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_vld=0, imem_req=0, flush=0, pending register=0.
REQ-035 On reset mid-transaction, SHALL abandon the outstanding request, and SHALL ignore an imem_ack seen in IDLE.

Configuration
REQ-036 With macro FETCH_MISALIGN_TRAP_EN defined, SHALL add output trap (1 bit).
REQ-037 With FETCH_MISALIGN_TRAP_EN defined, a redirect with alu_data[1:0]!=2'b00 SHALL use TRAP_VEC instead of alu_data and pulse trap together with flush.
REQ-038 Without FETCH_MISALIGN_TRAP_EN, SHALL omit the trap port and use {alu_data[31:2],2'b00} as the target.

Structure
REQ-039 Package fetch_pkg SHALL hold: enum fetch_state_e {IDLE,REQ,HOLD,DRAIN}, XLEN=32, INSTR_NOP=32'h0000_0013.
REQ-040 SHALL implement the fetch-address register and its next-address mux (+4 / target / pending / trap) as sub-module pc_next.
REQ-041 SHALL keep the FSM and the output registers in fetch_ctrl.

Verification
REQ-042 Reset release, ack every cycle, stall=0 -> imem_addr 0,4,8,...; instr_vld high continuously from the 2nd fetch cycle; pc=0,4,8.
REQ-043 Ack at addr 8, stall=1 for 3 cycles -> instr and pc=8 held 3 cycles, imem_req=0, then the fetch at 12.
REQ-044 br_sel=1, alu_data=32'h40, ack delayed 2 cycles -> flush 1 cycle, data at the old address discarded, next imem_addr=32'h40.
REQ-045 br_sel same cycle as ack -> instr_vld stays 0, next imem_addr=target; fetch at 32'hFFFF_FFFC -> next address 32'h0.
REQ-046 With FETCH_MISALIGN_TRAP_EN: alu_data=32'h42 -> trap and flush pulse, next imem_addr=32'h100. Without it -> next imem_addr=32'h40.
REQ-047 rst_n low during DRAIN -> all outputs at reset values immediately; an ack after release is ignored; fetch restarts at RESET_PC.
